// File: rtl/quad_encoder_pkg.sv
// Shared constants for the quadrature encoder input conditioner:
// register addresses, counter-bank select and the reset threshold.
package quad_encoder_pkg;

    localparam int ADDR_THRESH    = 0;
    localparam int ADDR_FLAGS     = 1;
    localparam int DEFAULT_FILTER = 4;

    // The address MSB picks between control registers and the error counters
    typedef enum logic {
        BANK_CTRL    = 1'b0,
        BANK_ERR_CNT = 1'b1
    } bank_e;

endpackage

// File: rtl/quad_encoder_glitch_filter.sv
// One encoder pin: 2-FF synchroniser followed by a counter that only lets a
// new level through once it has been stable for max(threshold,1) cycles.
module quad_encoder_glitch_filter #(
    parameter int pFILTER_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [pFILTER_BITS-1:0] threshold,
    input  logic                    async_in,
    output logic                    filt_out,
    output logic                    toggle
);

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    out_q, out_d;
    logic [pFILTER_BITS-1:0] cnt_q, cnt_d;
    logic [pFILTER_BITS-1:0] limit;

    always_comb begin
        // Threshold 0 and 1 both mean "pass the first mismatching sample"
        limit   = (threshold == '0) ? '0 : threshold - 1'b1;
        sync1_d = async_in;
        sync2_d = sync1_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        if (sync2_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            out_d = sync2_q;
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        toggle = (out_d != out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_out = out_q;

endmodule

// File: rtl/quad_encoder_filter.sv
// Glitch-filters every A/B encoder pin, flags illegal quadrature steps where
// A and B change together, and exposes threshold/flags/counters on Avalon-MM.
module quad_encoder_filter
    import quad_encoder_pkg::*;
#(
    parameter int pENCODERS       = 2,
    parameter int pFILTER_BITS    = 8,
    parameter int pERR_BITS       = 16,
    parameter int pDEFAULT_FILTER = DEFAULT_FILTER
) (
    input  logic                           iCLK,
    input  logic                           iRESET_N,
    input  logic [$clog2(pENCODERS):0]     iAVL_ADDRESS,
    input  logic                           iAVL_READ,
    input  logic                           iAVL_WRITE,
    input  logic [31:0]                    iAVL_WRITE_DATA,
    output logic [31:0]                    oAVL_READ_DATA,
    input  logic [pENCODERS-1:0]           iENCODER_A,
    input  logic [pENCODERS-1:0]           iENCODER_B,
    output logic [pENCODERS-1:0]           oENCODER_A,
    output logic [pENCODERS-1:0]           oENCODER_B
);

    localparam int ADDR_W = $clog2(pENCODERS) + 1;
    localparam int IDX_W  = (ADDR_W > 1) ? ADDR_W - 1 : 1;

    logic [pFILTER_BITS-1:0] thresh_q, thresh_d;
    logic [pENCODERS-1:0]    flags_q, flags_d;
    logic [pERR_BITS-1:0]    err_cnt_q [pENCODERS];
    logic [pERR_BITS-1:0]    err_cnt_d [pENCODERS];
    logic [31:0]             rdata_q, rdata_d;

    logic [pENCODERS-1:0]    toggle_a, toggle_b, illegal;
    logic [pENCODERS-1:0]    clr_mask;
    logic [IDX_W-1:0]        low_addr;
    bank_e                   bank;
    logic                    ctrl_wr;
    logic                    cnt_clr;
    logic                    unused_wdata;

    for (genvar n = 0; n < pENCODERS; n++) begin : g_chan
        quad_encoder_glitch_filter #(.pFILTER_BITS(pFILTER_BITS)) u_filt_a (
            .clk       (iCLK),
            .rst_n     (iRESET_N),
            .threshold (thresh_q),
            .async_in  (iENCODER_A[n]),
            .filt_out  (oENCODER_A[n]),
            .toggle    (toggle_a[n])
        );
        quad_encoder_glitch_filter #(.pFILTER_BITS(pFILTER_BITS)) u_filt_b (
            .clk       (iCLK),
            .rst_n     (iRESET_N),
            .threshold (thresh_q),
            .async_in  (iENCODER_B[n]),
            .filt_out  (oENCODER_B[n]),
            .toggle    (toggle_b[n])
        );
    end

    assign illegal      = toggle_a & toggle_b;
    assign bank         = bank_e'(iAVL_ADDRESS[ADDR_W-1]);
    assign unused_wdata = ^iAVL_WRITE_DATA;

    if (ADDR_W > 1) begin : g_low_addr
        assign low_addr = iAVL_ADDRESS[ADDR_W-2:0];
    end else begin : g_no_low_addr
        assign low_addr = '0;
    end

    always_comb begin
        thresh_d  = thresh_q;
        err_cnt_d = err_cnt_q;
        rdata_d   = rdata_q;
        cnt_clr   = 1'b0;
        ctrl_wr   = iAVL_WRITE && (bank == BANK_CTRL);

        if (ctrl_wr && (32'(low_addr) == ADDR_THRESH)) begin
            thresh_d = iAVL_WRITE_DATA[pFILTER_BITS-1:0];
        end

        // A new error wins over a same-cycle write-1-to-clear
        clr_mask = (ctrl_wr && (32'(low_addr) == ADDR_FLAGS)) ?
                   iAVL_WRITE_DATA[pENCODERS-1:0] : '0;
        flags_d  = (flags_q & ~clr_mask) | illegal;

        for (int n = 0; n < pENCODERS; n++) begin
            cnt_clr = iAVL_WRITE && (bank == BANK_ERR_CNT) && (32'(low_addr) == n);
            if (illegal[n]) begin
                if (cnt_clr) begin
                    err_cnt_d[n] = pERR_BITS'(1);
                end else if (err_cnt_q[n] != '1) begin
                    err_cnt_d[n] = err_cnt_q[n] + 1'b1;
                end
            end else if (cnt_clr) begin
                err_cnt_d[n] = '0;
            end
        end

        // Reads sample the pre-write state so read+write returns the old value
        if (iAVL_READ) begin
            rdata_d = '0;
            if (bank == BANK_CTRL) begin
                if (32'(low_addr) == ADDR_THRESH) begin
                    rdata_d = 32'(thresh_q);
                end else if (32'(low_addr) == ADDR_FLAGS) begin
                    rdata_d = 32'(flags_q);
                end
            end else if (32'(low_addr) < pENCODERS) begin
                rdata_d = 32'(err_cnt_q[low_addr]);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            thresh_q <= pFILTER_BITS'(pDEFAULT_FILTER);
            flags_q  <= '0;
            rdata_q  <= '0;
            for (int n = 0; n < pENCODERS; n++) begin
                err_cnt_q[n] <= '0;
            end
        end else begin
            thresh_q  <= thresh_d;
            flags_q   <= flags_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign oAVL_READ_DATA = rdata_q;

endmodule

// File: doc/quad_encoder_filter.md
Name: quad_encoder_filter

Overview:
Input conditioner placed directly upstream of the quadrature encoder counter. Per channel, it resynchronises the raw A/B pins and rejects glitches shorter than a programmable threshold. It presents clean A/B levels to the counter and detects illegal quadrature transitions, where A and B change together. Programmable threshold, sticky error flags and per-channel error counters are exposed on an Avalon-MM slave.

Parameters:
pENCODERS, 2, number of encoder channels (1..32)
pFILTER_BITS, 8, width of threshold and per-signal glitch counters
pERR_BITS, 16, width of per-channel illegal-transition counters (<=32)
pDEFAULT_FILTER, 4, threshold value after reset

Ports:
iCLK  in  1  system clock; all logic on rising edge
iRESET_N  in  1  asynchronous, active-low reset
iAVL_ADDRESS  in  $clog2(pENCODERS)+1  register address
iAVL_READ  in  1  read strobe
iAVL_WRITE  in  1  write strobe
iAVL_WRITE_DATA  in  32  write data
oAVL_READ_DATA  out  32  registered read data
iENCODER_A  in  pENCODERS  raw A pins (asynchronous)
iENCODER_B  in  pENCODERS  raw B pins (asynchronous)
oENCODER_A  out  pENCODERS  filtered A, to encoder counter
oENCODER_B  out  pENCODERS  filtered B, to encoder counter

Behaviour:
- Reset (async assert, release on clock): sync FFs, glitch counters, oENCODER_A/B, error flags and error counters = 0; threshold T = pDEFAULT_FILTER; oAVL_READ_DATA = 0.
- Sync: 2-FF synchroniser per pin; s = second stage.
- Glitch filter, independent per signal (2*pENCODERS instances):
  - s == out: cnt <= 0.
  - s != out and cnt >= max(T,1)-1: out <= s, cnt <= 0.
  - Otherwise: cnt <= cnt+1, saturating at all-ones.
  - T=0 and T=1 behave identically (no filtering).
  - Pin-to-output latency = 2 + max(T,1) cycles.
  - A pulse held stable for fewer than max(T,1) synced cycles never reaches out.
- Illegal transition: in any cycle where filtered A and filtered B of channel n both toggle, set flag[n] and increment err_cnt[n], saturating at 2^pERR_BITS-1. Filtered outputs still update; the block only reports the error, it does not correct it.
- Register map, address MSB=0:
  - addr 0: threshold, R/W, bits [pFILTER_BITS-1:0], upper bits read 0.
  - addr 1: sticky flags, R, bit n = flag[n]; write 1 clears, write 0 has no effect.
  - Other MSB=0 addresses read 0, writes ignored.
- Register map, address MSB=1: lower bits = channel index n.
  - Read returns err_cnt[n], zero-extended.
  - Any write clears err_cnt[n].
  - Index >= pENCODERS reads 0.
- Bus timing:
  - Read data is registered, valid the cycle after iAVL_READ; holds its last value otherwise.
  - No wait states.
  - Simultaneous read and write to the same address: read returns the old value.
- Collisions:
  - Flag clear and new error in the same cycle: flag stays set.
  - Counter clear and new error in the same cycle: counter = 1.
  - Counter at maximum: holds, no wrap.
- Threshold write mid-filter: counters are not cleared; the new T applies from the next cycle. A counter already >= new T-1 updates out on the next mismatch cycle.
- Reset asserted mid-glitch: all state is lost, outputs go to 0 immediately.

Decomposition:
- Package quad_encoder_pkg: register address constants (ADDR_THRESH=0, ADDR_FLAGS=1), MSB counter-bank select bit definition, default filter constant.
- Sub-module quad_encoder_glitch_filter: single-bit synchroniser + counter filter, parameterised by pFILTER_BITS. It takes threshold and sync input and produces a filtered bit. The top level instantiates it 2*pENCODERS times in a generate loop.

Test Plan:
- Reset, T=4: A0 rises and stays high -> oENCODER_A[0] rises exactly 6 cycles later. Read addr 0 -> 0x4.
- T=4: B1 high pulses of 3 synced cycles, then 4 cycles -> first pulse never appears; second appears 6 cycles after its rise, width 4.
- T=0 written, then A0 toggles every cycle -> oENCODER_A[0] follows with latency 3. Read addr 0 returns 0.
- T=2: A1 and B1 toggled on the same clock -> flag bit1 set; addr MSB=1, index 1 reads 1. Write 0x2 to addr 1 -> flag clears, counter stays 1.
- Error counter forced to 0xFFFF (pERR_BITS=16) by repeated illegal edges -> holds at 0xFFFF. Write to the counter in the same cycle as a new error -> reads 1.
- iRESET_N pulsed low mid-filter, asynchronously relative to iCLK -> outputs 0 with no clock edge; threshold reads 4; flags and counters read 0.
